sdram_pattern_tester: RTL and testbench
=======================================

Name: sdram_pattern_tester

Overview:
Parametrised SDRAM/Avalon-MM memory tester, successor to the single-pattern board RW test.
- Writes a selectable data pattern over a programmable address window, then reads back and compares.
- Honours waitrequest/readdatavalid and counts errors rather than only halting.
- Sits between the board button/LED logic and the SDRAM controller's slave port.

Parameters:
ADDR_W, 25, address width in words
DATA_W, 16, data width; must be 8..64
ERR_CNT_W, 16, error counter width
TIMEOUT, 1023, max cycles from read accept to readdatavalid

Ports:
iCLK  in  1  clock
iRST_n  in  1  reset, synchronous, active-low
iSTART  in  1  level; rising edge starts a run
iMODE  in  2  0 hash, 1 address, 2 walking-one, 3 checkerboard
iSTOP_ON_ERR  in  1  1 = go to FAIL at first mismatch
iADDR_LO  in  ADDR_W  first address, inclusive
iADDR_HI  in  ADDR_W  last address, inclusive
iSEED  in  32  hash seed; a free-running counter is typical
oADDRESS  out  ADDR_W  master address
oWRITE  out  1  write request
oWRITEDATA  out  DATA_W  write data
oREAD  out  1  read request
iWAITREQUEST  in  1  slave stall
iREADDATA  in  DATA_W  read data
iREADDATAVALID  in  1  read data qualifier
oBUSY  out  1  run in progress
oPASS  out  1  state PASS
oFAIL  out  1  state FAIL
oDONE  out  1  oPASS | oFAIL
oCFG_ERR  out  1  iADDR_LO > iADDR_HI at start
oTIMEOUT  out  1  readdatavalid timeout occurred
oERR_CNT  out  ERR_CNT_W  mismatch count, saturating
oFIRST_ERR_ADDR  out  ADDR_W  address of first mismatch
oSTATE  out  4  state encoding, for debug LEDs

Behaviour:
- Reset: every output is 0. State IDLE. The start edge detector is primed to 1 so a held-high iSTART does not trigger a run.
- Start edge: the run starts only from IDLE, PASS or FAIL; edges while busy are ignored. On start:
  - latch iMODE, iSTOP_ON_ERR, iADDR_LO, iADDR_HI, iSEED;
  - clear oERR_CNT, oFIRST_ERR_ADDR, oCFG_ERR, oTIMEOUT;
  - set addr to LO.
- If LO > HI: go to FAIL with oCFG_ERR=1 and make no bus access.
- Pattern P(addr), combinational from the latched config:
  - hash: h0 = seed + zero-extended addr; h1 = {h0[15:0],h0[31:16]} ^ seed; h2 = h1 + seed, all mod 2^32. P = low DATA_W bits of {h2,h1}.
  - address: P = addr, zero-extended or truncated to DATA_W.
  - walking-one: P = 1 << (addr mod DATA_W).
  - checkerboard: P = addr[0] ? 0xAA.. : 0x55.., DATA_W wide.
- States (oSTATE): IDLE 0, WR 1, WR_NEXT 2, GAP 3, RD 4, RD_WAIT 5, CHECK 6, RD_NEXT 7, FAIL 8, PASS 9.
- WR: oWRITE=1, oADDRESS=addr, oWRITEDATA=P. Hold all three stable while iWAITREQUEST=1. The cycle with oWRITE & !iWAITREQUEST is the accept; next state WR_NEXT with oWRITE=0.
- WR_NEXT: if addr==HI, set addr=LO and go to GAP; else addr+1 and go to WR. The end test is an equality compare, so HI = all-ones never wraps.
- GAP: 2 idle cycles, then RD.
- RD: oREAD=1, held until accepted; then RD_WAIT with oREAD=0 and the timeout counter cleared.
- RD_WAIT: on iREADDATAVALID, capture iREADDATA and go to CHECK. If the counter reaches TIMEOUT, set oTIMEOUT=1 and go to FAIL. Readdatavalid outside RD_WAIT is ignored.
- CHECK, on mismatch against P(addr):
  - if oERR_CNT was 0, load oFIRST_ERR_ADDR;
  - increment oERR_CNT, saturating at all-ones;
  - if stop-on-error, go to FAIL, else go to RD_NEXT.
- CHECK, on match: go to RD_NEXT.
- RD_NEXT: if addr==HI, go to PASS when oERR_CNT==0, else FAIL; otherwise addr+1 and go to RD.
- Only one outstanding read at a time.
- oBUSY=1 in states 1..7.
- Reset asserted mid-run, including with a request pending: all outputs return to reset values on the next edge.

Optional Feature:
SDRAM_TESTER_INV_PASS_EN
- Defined: after the first read pass completes with a PASS or continue outcome, a second write+read pass runs with data ~P(addr). The final verdict covers both passes. oERR_CNT accumulates across passes. oFIRST_ERR_ADDR keeps the earliest mismatch.
- Undefined: single pass only, with no inverted-pass logic.

Test Plan:
- Zero-wait slave, mode 1, LO=0x10, HI=0x17, ideal memory, start → 8 writes with data 0x0010..0x0017, then 8 reads; oPASS=1, oERR_CNT=0.
- Slave asserts waitrequest 3 cycles on every access → oWRITE/oREAD, oADDRESS and oWRITEDATA held stable; data still matches; PASS.
- Mode 0, stop_on_err=0, memory flips bit 3 at 0x12 and 0x15 → oFAIL=1, oERR_CNT=2, oFIRST_ERR_ADDR=0x12.
- Same fault with stop_on_err=1 → FAIL right after reading 0x12, no read of 0x13 issued, oERR_CNT=1.
- Readdatavalid withheld after a read accept → exactly TIMEOUT cycles later oFAIL=1, oTIMEOUT=1. LO=5, HI=4 → immediate FAIL with oCFG_ERR=1 and no bus activity.
- Reset mid-WR while waitrequest=1 → outputs 0 next cycle; a later start edge reruns from LO and passes.

Source files
------------

// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: Avalon-MM pattern write/read-back tester with error counting.
// Define SDRAM_TESTER_INV_PASS_EN to add a second pass using inverted data.
module sdram_pattern_tester #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int ERR_CNT_W = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  input  logic                 iSTART,
  input  logic [1:0]           iMODE,
  input  logic                 iSTOP_ON_ERR,
  input  logic [ADDR_W-1:0]    iADDR_LO,
  input  logic [ADDR_W-1:0]    iADDR_HI,
  input  logic [31:0]          iSEED,
  output logic [ADDR_W-1:0]    oADDRESS,
  output logic                 oWRITE,
  output logic [DATA_W-1:0]    oWRITEDATA,
  output logic                 oREAD,
  input  logic                 iWAITREQUEST,
  input  logic [DATA_W-1:0]    iREADDATA,
  input  logic                 iREADDATAVALID,
  output logic                 oBUSY,
  output logic                 oPASS,
  output logic                 oFAIL,
  output logic                 oDONE,
  output logic                 oCFG_ERR,
  output logic                 oTIMEOUT,
  output logic [ERR_CNT_W-1:0] oERR_CNT,
  output logic [ADDR_W-1:0]    oFIRST_ERR_ADDR,
  output logic [3:0]           oSTATE
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [3:0] {
    IDLE = 4'd0, WR = 4'd1, WR_NEXT = 4'd2, GAP = 4'd3, RD = 4'd4,
    RD_WAIT = 4'd5, CHECK = 4'd6, RD_NEXT = 4'd7, FAIL_S = 4'd8, PASS_S = 4'd9
  } state_t;
  state_t state_q, state_d;
  logic start_q, stop_q, stop_d, cfg_q, cfg_d, tmo_q, tmo_d;
  logic write_q, read_q, busy_q, pass_q, fail_q, done_q;
  logic [1:0] mode_q, mode_d;
  logic [ADDR_W-1:0] lo_q, lo_d, hi_q, hi_d, addr_q, addr_d, first_q, first_d;
  logic [31:0] seed_q, seed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, pat, exp_data;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                                                input logic [31:0] s);
    logic [31:0] h0, h1, h2;
    logic [DATA_W-1:0] p;
    h0 = s + 32'(a);
    h1 = {h0[15:0], h0[31:16]} ^ s;
    h2 = h1 + s;
    p = DATA_W'({h2, h1});
    if (m == 2'd1) p = DATA_W'(a);
    if (m == 2'd2) p = DATA_W'(1) << (a % ADDR_W'(DATA_W));
    if (m == 2'd3) for (int i = 0; i < DATA_W; i++) p[i] = a[0] == i[0];
    return p;
  endfunction
  assign pat = pattern(mode_q, addr_q, seed_q);
`ifdef SDRAM_TESTER_INV_PASS_EN
  logic inv_q, inv_d;
  assign exp_data = pat ^ {DATA_W{inv_q}};
`else
  assign exp_data = pat;
`endif
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    stop_d  = stop_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    seed_d  = seed_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    first_d = first_q;
    cfg_d   = cfg_q;
    tmo_d   = tmo_q;
`ifdef SDRAM_TESTER_INV_PASS_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      IDLE, PASS_S, FAIL_S: if (iSTART && !start_q) begin
        mode_d  = iMODE;
        stop_d  = iSTOP_ON_ERR;
        lo_d    = iADDR_LO;
        hi_d    = iADDR_HI;
        seed_d  = iSEED;
        addr_d  = iADDR_LO;
        err_d   = '0;
        first_d = '0;
        tmo_d   = 1'b0;
        cfg_d   = iADDR_LO > iADDR_HI;
        state_d = iADDR_LO > iADDR_HI ? FAIL_S : WR;
`ifdef SDRAM_TESTER_INV_PASS_EN
        inv_d   = 1'b0;
`endif
      end
      WR: state_d = iWAITREQUEST ? WR : WR_NEXT;
      WR_NEXT: begin
        addr_d  = addr_q == hi_q ? lo_q : addr_q + ADDR_W'(1);
        state_d = addr_q == hi_q ? GAP : WR;
        cnt_d   = '0;
      end
      GAP: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == CW'(1) ? RD : GAP;
      end
      RD: begin
        cnt_d   = '0;
        state_d = iWAITREQUEST ? RD : RD_WAIT;
      end
      RD_WAIT: if (iREADDATAVALID) begin
        rdata_d = iREADDATA;
        state_d = CHECK;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        tmo_d   = 1'b1;
        state_d = FAIL_S;
      end else cnt_d = cnt_q + CW'(1);
      CHECK: begin
        state_d = RD_NEXT;
        if (rdata_q != exp_data) begin
          first_d = err_q == '0 ? addr_q : first_q;
          err_d   = err_q + ERR_CNT_W'(~&err_q);
          state_d = stop_q ? FAIL_S : RD_NEXT;
        end
      end
      RD_NEXT:
`ifdef SDRAM_TESTER_INV_PASS_EN
        if (addr_q == hi_q && !inv_q) begin
          inv_d   = 1'b1;
          addr_d  = lo_q;
          state_d = WR;
        end else
`endif
        if (addr_q == hi_q) state_d = err_q == '0 ? PASS_S : FAIL_S;
        else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = RD;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      start_q <= 1'b1;
      mode_q  <= '0;
      stop_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      seed_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      first_q <= '0;
      cfg_q   <= 1'b0;
      tmo_q   <= 1'b0;
      write_q <= 1'b0;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SDRAM_TESTER_INV_PASS_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= iSTART;
      mode_q  <= mode_d;
      stop_q  <= stop_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      seed_q  <= seed_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      first_q <= first_d;
      cfg_q   <= cfg_d;
      tmo_q   <= tmo_d;
      write_q <= state_d == WR;
      read_q  <= state_d == RD;
      busy_q  <= state_d inside {WR, WR_NEXT, GAP, RD, RD_WAIT, CHECK, RD_NEXT};
      pass_q  <= state_d == PASS_S;
      fail_q  <= state_d == FAIL_S;
      done_q  <= state_d inside {PASS_S, FAIL_S};
`ifdef SDRAM_TESTER_INV_PASS_EN
      inv_q   <= inv_d;
`endif
    end
  end
  assign oADDRESS        = addr_q;
  assign oWRITE          = write_q;
  assign oWRITEDATA      = exp_data;
  assign oREAD           = read_q;
  assign oBUSY           = busy_q;
  assign oPASS           = pass_q;
  assign oFAIL           = fail_q;
  assign oDONE           = done_q;
  assign oCFG_ERR        = cfg_q;
  assign oTIMEOUT        = tmo_q;
  assign oERR_CNT        = err_q;
  assign oFIRST_ERR_ADDR = first_q;
  assign oSTATE          = state_q;
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb_sdram_pattern_tester: directed runs against a bench-side Avalon slave and pattern model.
module tb_sdram_pattern_tester;
  localparam int AW = 25, DW = 16, EW = 16, TO = 20;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b1, stop_err = 1'b0;
  logic [1:0] mode = '0;
  logic [AW-1:0] lo = '0, hi = '0, address, first_err;
  logic [31:0] seed = '0;
  logic write, read, waitreq, rvalid = 1'b0, busy, pass, fail, done, cfg_err, tmo;
  logic [DW-1:0] wdata, rdata = '0;
  logic [EW-1:0] err_cnt;
  logic [3:0] state;
  int n_chk = 0, n_fail = 0;
  int waits = 0, wc = 0, wr_cnt = 0, rd_cnt = 0, act = 0;
  logic withhold = 1'b0, fault_en = 1'b0;
  logic [AW-1:0] fa = '0, fb = '0, cur_lo = '0, p_addr = '0;
  logic [1:0] cur_m = '0;
  logic [31:0] cur_seed = '0;
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] first_wd = '0, p_data = '0;
  logic stall_p = 1'b0, p_wr = 1'b0, p_rd = 1'b0;

  sdram_pattern_tester #(.ADDR_W(AW), .DATA_W(DW), .ERR_CNT_W(EW), .TIMEOUT(TO)) dut (
    .iCLK(clk), .iRST_n(rst_n), .iSTART(start), .iMODE(mode), .iSTOP_ON_ERR(stop_err),
    .iADDR_LO(lo), .iADDR_HI(hi), .iSEED(seed), .oADDRESS(address), .oWRITE(write),
    .oWRITEDATA(wdata), .oREAD(read), .iWAITREQUEST(waitreq), .iREADDATA(rdata),
    .iREADDATAVALID(rvalid), .oBUSY(busy), .oPASS(pass), .oFAIL(fail), .oDONE(done),
    .oCFG_ERR(cfg_err), .oTIMEOUT(tmo), .oERR_CNT(err_cnt), .oFIRST_ERR_ADDR(first_err),
    .oSTATE(state));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  // Expected write data from the pattern definitions (16-bit data width)
  function automatic logic [DW-1:0] model_p(input logic [1:0] m, input logic [AW-1:0] a,
                                            input logic [31:0] s);
    logic [31:0] h0, h1;
    h0 = s + {7'd0, a};
    h1 = {h0[15:0], h0[31:16]} ^ s;
    case (m)
      2'd0: return h1[15:0];
      2'd1: return a[15:0];
      2'd2: return 16'd1 << (a % 16);
      default: return a[0] ? 16'hAAAA : 16'h5555;
    endcase
  endfunction

  assign waitreq = (write || read) && (wc < waits);

  always @(posedge clk) begin
    if (!rst_n) begin
      wc <= 0;
      rvalid <= 1'b0;
    end else begin
      wc <= ((write || read) && waitreq) ? wc + 1 : 0;
      if (write && !waitreq) mem[address[7:0]] <= wdata;
      rvalid <= read && !waitreq && !withhold;
      rdata <= mem[address[7:0]] ^ ((fault_en && (address == fa || address == fb)) ? 16'h0008 : 16'h0);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) stall_p = 1'b0;
    else begin
      chk("busy_vs_state", busy, state inside {[4'd1:4'd7]});
      chk("done_vs_verdict", done, pass | fail);
      chk("rw_exclusive", write & read, 1'b0);
      if ((write || read) && stall_p) begin
        chk("hold_addr", address, p_addr);
        chk("hold_wr", write, p_wr);
        chk("hold_rd", read, p_rd);
        if (write) chk("hold_wdata", wdata, p_data);
      end
      if (write || read) act++;
      if (write && !waitreq) begin
        chk("wr_addr", address, cur_lo + AW'(wr_cnt));
        chk("wr_data", wdata, model_p(cur_m, cur_lo + AW'(wr_cnt), cur_seed));
        if (wr_cnt == 0) first_wd = wdata;
        wr_cnt++;
      end
      if (read && !waitreq) begin
        chk("rd_addr", address, cur_lo + AW'(rd_cnt));
        rd_cnt++;
      end
      stall_p = (write || read) && waitreq;
      p_addr = address;
      p_data = wdata;
      p_wr = write;
      p_rd = read;
    end
  end

  task automatic kick(input logic [1:0] m, input logic st, input logic [AW-1:0] l,
                      input logic [AW-1:0] h, input logic [31:0] s, input int w);
    @(negedge clk);
    mode = m; stop_err = st; lo = l; hi = h; seed = s; waits = w; start = 1'b0;
    cur_m = m; cur_lo = l; cur_seed = s; wr_cnt = 0; rd_cnt = 0; act = 0;
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic run(input string tag, input logic [1:0] m, input logic st, input logic [AW-1:0] l,
                     input logic [AW-1:0] h, input logic [31:0] s, input int w);
    int n, nf, cyc, exp_rd;
    logic [AW-1:0] f1;
    kick(m, st, l, h, s, w);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!done && cyc < 5000);
    chk({tag, "_done_in_budget"}, done, 1'b1);
    n = int'(h) - int'(l) + 1;
    nf = 0; f1 = '0;
    for (int a = int'(l); a <= int'(h); a++)
      if (fault_en && (AW'(a) == fa || AW'(a) == fb)) begin
        if (nf == 0) f1 = AW'(a);
        nf++;
      end
    exp_rd = (nf > 0 && st) ? int'(f1) - int'(l) + 1 : n;
    chk({tag, "_pass"}, pass, nf == 0);
    chk({tag, "_fail"}, fail, nf != 0);
    chk({tag, "_err_cnt"}, err_cnt, (nf > 0 && st) ? 1 : nf);
    chk({tag, "_first_err"}, first_err, f1);
    chk({tag, "_writes"}, wr_cnt, n);
    chk({tag, "_reads"}, rd_cnt, exp_rd);
    chk({tag, "_timeout"}, tmo, 1'b0);
    chk({tag, "_cfg_err"}, cfg_err, 1'b0);
    chk({tag, "_state"}, state, nf == 0 ? 4'd9 : 4'd8);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {address, write, wdata, read, busy, pass, fail, done, cfg_err, tmo, err_cnt, first_err, state}, '0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("held_start_no_run", {busy, state}, '0);

    run("addr", 2'd1, 1'b0, 25'h10, 25'h17, 32'h0, 0);
    chk("lit_mode1_first", first_wd, 16'h0010);
    run("wait3", 2'd3, 1'b0, 25'h10, 25'h17, 32'h0, 3);
    chk("lit_checker_first", first_wd, 16'h5555);
    run("walk", 2'd2, 1'b0, 25'h13, 25'h25, 32'h0, 1);
    chk("lit_walk_first", first_wd, 16'h0008);
    fault_en = 1'b1; fa = 25'h12; fb = 25'h15;
    run("hash_cont", 2'd0, 1'b0, 25'h10, 25'h17, 32'h12345678, 0);
    chk("lit_hash_first", first_wd, 16'h444C);
    chk("lit_hash_err", err_cnt, 16'd2);
    chk("lit_hash_first_err", first_err, 25'h12);
    run("hash_stop", 2'd0, 1'b1, 25'h10, 25'h17, 32'h12345678, 2);
    chk("lit_stop_reads", rd_cnt, 3);
    fault_en = 1'b0;
    run("top_edge", 2'd1, 1'b0, 25'h1FFFFFE, 25'h1FFFFFF, 32'h0, 0);
    chk("lit_top_first", first_wd, 16'hFFFE);

    // Read data withheld: failure expected exactly TO cycles after the read accept edge
    withhold = 1'b1;
    kick(2'd1, 1'b0, 25'h20, 25'h20, 32'h0, 0);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (state != 4'd5 && cyc < 200);
    chk("to_reached_rd_wait", state, 4'd5);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!fail && cyc < 200);
    chk("to_cycles", cyc, TO);
    chk("to_flag", tmo, 1'b1);
    chk("to_fail", fail, 1'b1);
    chk("to_err_cnt", err_cnt, 16'd0);
    withhold = 1'b0;

    kick(2'd1, 1'b0, 25'h5, 25'h4, 32'h0, 0);
    @(posedge clk); #1;
    chk("cfg_fail", fail, 1'b1);
    chk("cfg_flag", cfg_err, 1'b1);
    chk("cfg_tmo_cleared", tmo, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("cfg_no_bus", act, 0);

    kick(2'd1, 1'b0, 25'h10, 25'h17, 32'h0, 50);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!write && cyc < 50);
    chk("rst_mid_in_wr", write, 1'b1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_outputs", {address, write, wdata, read, busy, pass, fail, done, cfg_err, tmo, err_cnt, first_err, state}, '0);
    @(negedge clk); rst_n = 1'b1;
    run("after_rst", 2'd1, 1'b0, 25'h10, 25'h17, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
